// File: rtl/arqt1_sysid_pkg.sv
// Shared types and constants for the system-ID checker.
// Address map of the sysid slave and default build-time expectations.
package arqt1_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_RD_TS,
        ST_EVAL,
        ST_DONE
    } state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEF_EXPECTED_ID = 32'h0000_0000;
    localparam logic [31:0] DEF_EXPECTED_TS = 32'd1554229495;

    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/arqt1_sysid_checker_timer.sv
// Per-word stall timer: counts waitrequest cycles and timeout retries.
// expire_o drops the read for one cycle; exhausted_o flags the last retry.
module arqt1_avm_read_timer
    import arqt1_sysid_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRIES    = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic stall_i,
    output logic expire_o,
    output logic exhausted_o
);

    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT_CYCLES);

    logic [WW-1:0] wait_q, wait_d;
    logic [2:0]    retry_q, retry_d;

    assign expire_o    = (wait_q == WAIT_MAX);
    assign exhausted_o = expire_o && (retry_q >= 3'(MAX_RETRIES));

    always_comb begin
        wait_d  = wait_q;
        retry_d = retry_q;
        if (clear_i) begin
            wait_d  = '0;
            retry_d = '0;
        end else if (expire_o) begin
            wait_d  = '0;
            retry_d = sat_inc3(retry_q);
        end else if (stall_i && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_q  <= '0;
            retry_q <= '0;
        end else begin
            wait_q  <= wait_d;
            retry_q <= retry_d;
        end
    end

endmodule

// File: rtl/arqt1_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words
// and compares them with build-time expectations for boot gating.
module arqt1_sysid_checker
    import arqt1_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
    parameter bit          CHECK_TS       = 1'b1,
    parameter bit          AUTO_START     = 1'b1,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter int          MAX_RETRIES    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_e      state_q, state_d;
    logic        gap_q, gap_d;
    logic        pending_q, pending_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic        pass_q, pass_d;
    logic        idm_q, idm_d;
    logic        tsm_q, tsm_d;
    logic        to_q, to_d;

    logic launch, accept, expire, exhausted;
    logic id_bad, ts_bad;

    assign launch = ((state_q == ST_IDLE) || (state_q == ST_DONE))
                    && (start || pending_q);

    // Read is withheld in the inter-read gap and in the retry gap.
    assign avm_read = ((state_q == ST_RD_ID) || (state_q == ST_RD_TS))
                      && !gap_q && !expire;
    assign avm_address = (state_q == ST_RD_TS) ? SYSID_ADDR_TS
                                               : SYSID_ADDR_ID;
    assign accept = avm_read && !avm_waitrequest;

    arqt1_avm_read_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) u_timer (
        .clk_i       (clock),
        .rst_i       (reset),
        .clear_i     (launch || accept),
        .stall_i     (avm_read && avm_waitrequest),
        .expire_o    (expire),
        .exhausted_o (exhausted)
    );

    assign id_bad = (id_q != EXPECTED_ID);
    assign ts_bad = (ts_q != EXPECTED_TS);

    always_comb begin
        state_d   = state_q;
        gap_d     = 1'b0;
        pending_d = pending_q;
        id_d      = id_q;
        ts_d      = ts_q;
        pass_d    = pass_q;
        idm_d     = idm_q;
        tsm_d     = tsm_q;
        to_d      = to_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (launch) begin
                    state_d   = ST_RD_ID;
                    pending_d = 1'b0;
                    id_d      = '0;
                    ts_d      = '0;
                    pass_d    = 1'b0;
                    idm_d     = 1'b0;
                    tsm_d     = 1'b0;
                    to_d      = 1'b0;
                end
            end
            ST_RD_ID: begin
                if (accept) begin
                    id_d    = avm_readdata;
                    gap_d   = 1'b1;
                    state_d = ST_RD_TS;
                end else if (exhausted) begin
                    to_d    = 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_RD_TS: begin
                if (accept) begin
                    ts_d    = avm_readdata;
                    state_d = ST_EVAL;
                end else if (exhausted) begin
                    to_d    = 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                idm_d   = id_bad;
                tsm_d   = ts_bad;
                pass_d  = !to_q && !id_bad && !(CHECK_TS && ts_bad);
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gap_q     <= 1'b0;
            pending_q <= AUTO_START;
            id_q      <= '0;
            ts_q      <= '0;
            pass_q    <= 1'b0;
            idm_q     <= 1'b0;
            tsm_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            pending_q <= pending_d;
            id_q      <= id_d;
            ts_q      <= ts_d;
            pass_q    <= pass_d;
            idm_q     <= idm_d;
            tsm_q     <= tsm_d;
            to_q      <= to_d;
        end
    end

    assign busy        = (state_q == ST_RD_ID) || (state_q == ST_RD_TS)
                         || (state_q == ST_EVAL);
    assign done        = (state_q == ST_DONE);
    assign pass        = pass_q;
    assign id_mismatch = idm_q;
    assign ts_mismatch = tsm_q;
    assign timeout     = to_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;

endmodule
